// File: rtl/collenda_onchip_memory_dp_if.sv
// Avalon-MM pipelined slave port bundle for the dual-port on-chip memory.
// Signals: address, chipselect, read, write, byteenable, writedata,
//          readdata, readdatavalid, waitrequest.
interface collenda_onchip_memory_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/collenda_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip memory with post-reset clear engine.
// Ports: clk, reset_n (async, active low), clken, s1/s2 (slave), busy.
module collenda_onchip_memory_dp #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 10,
    parameter int                DEPTH          = 1024,
    parameter int                READ_LATENCY   = 1,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    collenda_onchip_memory_dp_if.slave s1,
    collenda_onchip_memory_dp_if.slave s2,
    output logic busy
);
    localparam int NP   = 2;
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr     [NP];
    logic              cs       [NP];
    logic              rd       [NP];
    logic              wr       [NP];
    logic [BE_W-1:0]   be       [NP];
    logic [DATA_W-1:0] wd       [NP];
    logic              waitreq  [NP];
    logic              acc      [NP];
    logic              acc_rd   [NP];
    logic              wr_en    [NP];
    logic              in_range [NP];
    logic              collide;

    logic              v0_q [NP];
    logic              v1_q [NP];
    logic [DATA_W-1:0] d0_q [NP];
    logic [DATA_W-1:0] d1_q [NP];
    logic              rdv  [NP];
    logic [DATA_W-1:0] rdat [NP];

    assign addr[0] = s1.address;
    assign addr[1] = s2.address;
    assign cs[0]   = s1.chipselect;
    assign cs[1]   = s2.chipselect;
    assign rd[0]   = s1.read;
    assign rd[1]   = s2.read;
    assign wr[0]   = s1.write;
    assign wr[1]   = s2.write;
    assign be[0]   = s1.byteenable;
    assign be[1]   = s2.byteenable;
    assign wd[0]   = s1.writedata;
    assign wd[1]   = s2.writedata;

    assign busy = (state_q == CLEAR);

    // Same-address write pair: s1 wins, s2 retries next cycle.
    assign collide = cs[0] & wr[0] & cs[1] & wr[1]
                   & (addr[0] == addr[1]);

    always_comb begin
        waitreq[0] = ~reset_n | ~clken | busy;
        waitreq[1] = ~reset_n | ~clken | busy | collide;
        for (int p = 0; p < NP; p++) begin
            acc[p]      = cs[p] & (rd[p] | wr[p]) & ~waitreq[p];
            acc_rd[p]   = acc[p] & rd[p] & ~wr[p];
            in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
            wr_en[p]    = acc[p] & wr[p] & in_range[p];
        end
    end

    // Clear engine
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        unique case (state_q)
            CLEAR: begin
                if (clken && reset_n) begin
                    clr_we = 1'b1;
                    if (clr_addr_q == LAST) begin
                        state_d = READY;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Array write side: clear engine and both ports never overlap
    // (ports stall while clearing; s1/s2 same-address writes serialize).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end
        for (int p = 0; p < NP; p++) begin
            if (wr_en[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[p][b]) begin
                        mem[addr[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline; reads sample the pre-edge array (old data).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NP; p++) begin
                v0_q[p] <= 1'b0;
                v1_q[p] <= 1'b0;
                d0_q[p] <= '0;
                d1_q[p] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < NP; p++) begin
                v0_q[p] <= acc_rd[p];
                if (acc_rd[p]) begin
                    d0_q[p] <= in_range[p] ? mem[addr[p]] : '0;
                end
                v1_q[p] <= v0_q[p];
                if (v0_q[p]) begin
                    d1_q[p] <= d0_q[p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            if (READ_LATENCY == 2) begin
                rdv[p]  = clken & v1_q[p];
                rdat[p] = d1_q[p];
            end else begin
                rdv[p]  = clken & v0_q[p];
                rdat[p] = d0_q[p];
            end
        end
    end

    assign s1.waitrequest   = waitreq[0];
    assign s2.waitrequest   = waitreq[1];
    assign s1.readdatavalid = rdv[0];
    assign s2.readdatavalid = rdv[1];
    assign s1.readdata      = rdat[0];
    assign s2.readdata      = rdat[1];
endmodule

// File: tb/tb_collenda_onchip_memory_dp.sv
// Directed bench for the dual-port on-chip memory.
// dut_a: 1024 words, latency 1; dut_b: 1000 words, latency 2.
module tb_collenda_onchip_memory_dp;
    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic busy_a, busy_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    collenda_onchip_memory_dp_if a1 ();
    collenda_onchip_memory_dp_if a2 ();
    collenda_onchip_memory_dp_if b1 ();
    collenda_onchip_memory_dp_if b2 ();

    collenda_onchip_memory_dp #(
        .DEPTH(1024), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
        .CLEAR_VALUE(32'hA5A5A5A5)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1(a1), .s2(a2), .busy(busy_a)
    );

    collenda_onchip_memory_dp #(
        .DEPTH(1000), .READ_LATENCY(2), .CLEAR_ON_RESET(1),
        .CLEAR_VALUE(32'hA5A5A5A5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1(b1), .s2(b2), .busy(busy_b)
    );

    // which: 0=a1 1=a2 2=b1 3=b2
    task automatic drive(input int which, input logic cs, input logic r,
                         input logic w, input logic [9:0] ad,
                         input logic [3:0] be, input logic [31:0] wd);
        case (which)
            0: begin a1.chipselect = cs; a1.read = r; a1.write = w;
                     a1.address = ad; a1.byteenable = be; a1.writedata = wd; end
            1: begin a2.chipselect = cs; a2.read = r; a2.write = w;
                     a2.address = ad; a2.byteenable = be; a2.writedata = wd; end
            2: begin b1.chipselect = cs; b1.read = r; b1.write = w;
                     b1.address = ad; b1.byteenable = be; b1.writedata = wd; end
            default: begin b2.chipselect = cs; b2.read = r; b2.write = w;
                     b2.address = ad; b2.byteenable = be; b2.writedata = wd; end
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        int cnt;
        int bad;
        reset_n = 1'b0;
        clken   = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, busy_b, a1.waitrequest, a2.waitrequest,
             b1.waitrequest, b2.waitrequest} !== 6'b111111) begin
            errors++;
            $display("FAIL reset_busy_wait got %b%b%b%b%b%b req 111111",
                     busy_a, busy_b, a1.waitrequest, a2.waitrequest,
                     b1.waitrequest, b2.waitrequest);
        end
        checks++;
        if ({a1.readdatavalid, a2.readdatavalid, b1.readdatavalid,
             b2.readdatavalid} !== 4'b0000 || a1.readdata !== 32'h0
            || b2.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_out rdv %b%b%b%b data %h %h req 0",
                     a1.readdatavalid, a2.readdatavalid, b1.readdatavalid,
                     b2.readdatavalid, a1.readdata, b2.readdata);
        end
        reset_n = 1'b1;
        cnt = 0;
        bad = 0;
        while (busy_a && cnt < 3000) begin
            if (!a1.waitrequest || !a2.waitrequest) bad++;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 1024) begin
            errors++;
            $display("FAIL clear_len got %0d req 1024", cnt);
        end
        checks++;
        if (bad !== 0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_wait bad %0d busy_b %b req 0 0", bad, busy_b);
        end
        drive(0, 1'b1, 1'b1, 1'b0, 10'h3FF, 4'hF, '0);
        #1;
        checks++;
        if (a1.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL ready_wait got %b req 0", a1.waitrequest);
        end
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL clear_read rdv %b data %h req 1 a5a5a5a5",
                     a1.readdatavalid, a1.readdata);
        end
        idle_all();
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rdv_single got %b req 0", a1.readdatavalid);
        end
    endtask

    task automatic test_byteenable();
        drive(0, 1'b1, 1'b0, 1'b1, 10'h010, 4'hF, 32'h11223344);
        @(negedge clk);
        idle_all();
        drive(1, 1'b1, 1'b0, 1'b1, 10'h010, 4'b0101, 32'hFFFFFFFF);
        @(negedge clk);
        idle_all();
        drive(1, 1'b1, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        #1;
        checks++;
        if (a2.waitrequest !== 1'b0 || a2.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL be_accept wait %b rdv %b req 0 0",
                     a2.waitrequest, a2.readdatavalid);
        end
        @(negedge clk);
        checks++;
        if (a2.readdatavalid !== 1'b1 || a2.readdata !== 32'h11FF33FF) begin
            errors++;
            $display("FAIL be_read rdv %b data %h req 1 11ff33ff",
                     a2.readdatavalid, a2.readdata);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_latency2();
        drive(2, 1'b1, 1'b0, 1'b1, 10'h010, 4'hF, 32'h11223344);
        @(negedge clk);
        idle_all();
        drive(3, 1'b1, 1'b0, 1'b1, 10'h010, 4'b0101, 32'hFFFFFFFF);
        @(negedge clk);
        idle_all();
        drive(3, 1'b1, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        @(negedge clk);
        idle_all();
        checks++;
        if (b2.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL lat2_early got %b req 0", b2.readdatavalid);
        end
        @(negedge clk);
        checks++;
        if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'h11FF33FF) begin
            errors++;
            $display("FAIL lat2_read rdv %b data %h req 1 11ff33ff",
                     b2.readdatavalid, b2.readdata);
        end
        // 0x3F0 lies beyond dut_b's 1000 words
        drive(2, 1'b1, 1'b0, 1'b1, 10'h3F0, 4'hF, 32'h12345678);
        @(negedge clk);
        checks++;
        if (b2.readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL lat2_single got %b req 0", b2.readdatavalid);
        end
        idle_all();
        drive(3, 1'b1, 1'b1, 1'b0, 10'h3F0, 4'hF, '0);
        @(negedge clk);
        idle_all();
        @(negedge clk);
        checks++;
        if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read rdv %b data %h req 1 0",
                     b2.readdatavalid, b2.readdata);
        end
        @(negedge clk);
    endtask

    task automatic test_collision();
        drive(0, 1'b1, 1'b0, 1'b1, 10'h020, 4'hF, 32'hAAAA0000);
        drive(1, 1'b1, 1'b0, 1'b1, 10'h020, 4'hF, 32'h0000BBBB);
        #1;
        checks++;
        if (a1.waitrequest !== 1'b0 || a2.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL coll_wait s1 %b s2 %b req 0 1",
                     a1.waitrequest, a2.waitrequest);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (a2.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL coll_retry got %b req 0", a2.waitrequest);
        end
        @(negedge clk);
        idle_all();
        drive(0, 1'b1, 1'b1, 1'b0, 10'h020, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'h0000BBBB) begin
            errors++;
            $display("FAIL coll_read rdv %b data %h req 1 0000bbbb",
                     a1.readdatavalid, a1.readdata);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_rdw();
        drive(0, 1'b1, 1'b0, 1'b1, 10'h030, 4'hF, 32'h1);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 10'h030, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 1'b1, 10'h030, 4'hF, 32'hDEADBEEF);
        #1;
        checks++;
        if (a1.waitrequest !== 1'b0 || a2.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rdw_wait s1 %b s2 %b req 0 0",
                     a1.waitrequest, a2.waitrequest);
        end
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'h1) begin
            errors++;
            $display("FAIL rdw_old rdv %b data %h req 1 00000001",
                     a1.readdatavalid, a1.readdata);
        end
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdw_new rdv %b data %h req 1 deadbeef",
                     a1.readdatavalid, a1.readdata);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int seen;
        int bad_order;
        int bad_stall;
        int nxt;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'b0, 1'b1, 10'(i), 4'hF, 32'h100 + i);
            @(negedge clk);
        end
        idle_all();
        @(negedge clk);
        seen = 0;
        bad_order = 0;
        bad_stall = 0;
        nxt = 0;
        for (int c = 0; c < 16; c++) begin
            clken = !(c >= 4 && c <= 6);
            if (clken && nxt < 8) begin
                drive(0, 1'b1, 1'b1, 1'b0, 10'(nxt), 4'hF, '0);
                nxt++;
            end else begin
                drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end
            #1;
            if (a1.readdatavalid === 1'b1) begin
                if (!clken) bad_stall++;
                if (a1.readdata !== 32'h100 + seen) bad_order++;
                seen++;
            end
            @(negedge clk);
        end
        clken = 1'b1;
        idle_all();
        checks++;
        if (seen !== 8) begin
            errors++;
            $display("FAIL b2b_count got %0d req 8", seen);
        end
        checks++;
        if (bad_order !== 0 || bad_stall !== 0) begin
            errors++;
            $display("FAIL b2b_order bad_data %0d rdv_in_stall %0d req 0 0",
                     bad_order, bad_stall);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (500) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || a1.waitrequest !== 1'b1
            || a2.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL midreset busy %b wait %b%b req 1 11",
                     busy_a, a1.waitrequest, a2.waitrequest);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        while (busy_a && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 1024) begin
            errors++;
            $display("FAIL reclear_len got %0d req 1024", cnt);
        end
        drive(0, 1'b1, 1'b1, 1'b0, 10'h010, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (a1.readdatavalid !== 1'b1 || a1.readdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reclear_read rdv %b data %h req 1 a5a5a5a5",
                     a1.readdatavalid, a1.readdata);
        end
        idle_all();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_byteenable();
        test_latency2();
        test_collision();
        test_rdw();
        test_back_to_back();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
